// File: rtl/demux2_pkg.sv
// Shared constants and types for the 1:2 stream demultiplexer.
// Port identifiers name the in_sel encoding; stat_t is the optional beat-counter type.
package demux2_pkg;

    localparam logic PORT0  = 1'b0;
    localparam logic PORT1  = 1'b1;
    localparam int   STAT_W = 16;

    typedef logic [STAT_W-1:0] stat_t;

endpackage

// File: rtl/demux2_stream_sync_fifo.sv
// Single-clock FIFO used as one output queue of demux2_stream.
// DEPTH must be a power of two, so the pointers wrap without any extra compare.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    // Full and empty come from registered state only, so a same-cycle pop
    // never makes room for a push, and a push into an empty queue is not
    // visible at the head until the following cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage is reset as well so the head reads 0 while reset is
    // held; this is affordable only because DEPTH is tiny.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/demux2_stream.sv
// 1:2 valid/ready demultiplexer: in_sel steers each accepted beat into one of two FIFOs.
// Define DEMUX2_STREAM_STATS_EN to add saturating per-port accepted-beat counters cnt0/cnt1.
module demux2_stream
    import demux2_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             in_ready,
    output logic             out0_valid,
    output logic [WIDTH-1:0] out0_data,
    input  logic             out0_ready,
    output logic             out1_valid,
    output logic [WIDTH-1:0] out1_data,
    input  logic             out1_ready
`ifdef DEMUX2_STREAM_STATS_EN
    ,
    output stat_t            cnt0,
    output stat_t            cnt1
`endif
);

    logic empty0, full0, empty1, full1;
    logic accept, push0, push1;

    // Only the selected port's fullness gates the input, so a full port stalls
    // the producer even when the other port has room; this preserves per-port order.
    assign in_ready = (in_sel == PORT1) ? !full1 : !full0;
    assign accept   = in_valid && in_ready;
    assign push0    = accept && (in_sel == PORT0);
    assign push1    = accept && (in_sel == PORT1);

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push0),
        .push_data (in_data),
        .pop       (out0_ready),
        .head      (out0_data),
        .empty     (empty0),
        .full      (full0)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push1),
        .push_data (in_data),
        .pop       (out1_ready),
        .head      (out1_data),
        .empty     (empty1),
        .full      (full1)
    );

`ifdef DEMUX2_STREAM_STATS_EN
    stat_t cnt0_q, cnt0_d;
    stat_t cnt1_q, cnt1_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (push0 && (cnt0_q != '1)) cnt0_d = cnt0_q + stat_t'(1);
        if (push1 && (cnt1_q != '1)) cnt1_d = cnt1_q + stat_t'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux2_stream.sv
// Directed self-checking bench for demux2_stream (WIDTH=8, DEPTH=2).
// Inputs change 1 ns after each rising edge; outputs are checked at that same point.
module tb_demux2_stream;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_ready;
    logic       out0_valid, out1_valid;
    logic [7:0] out0_data, out1_data;
    logic       out0_ready, out1_ready;
`ifdef DEMUX2_STREAM_STATS_EN
    logic [15:0] cnt0, cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux2_stream #(.WIDTH(8), .DEPTH(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready)
`ifdef DEMUX2_STREAM_STATS_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    initial begin
        reset_n    = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        #2;
        check("rst_out0_valid", out0_valid, 1'b0);
        check("rst_out1_valid", out1_valid, 1'b0);
        check("rst_out0_data",  out0_data,  8'h00);
        check("rst_out1_data",  out1_data,  8'h00);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1'b1);

        // Single beat to port 0
        out0_ready = 1'b1;
        drive(1'b1, 1'b0, 8'hA5);
        check("t1_in_ready", in_ready, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        check("t1_out0_valid", out0_valid, 1'b1);
        check("t1_out0_data",  out0_data,  8'hA5);
        check("t1_out1_valid", out1_valid, 1'b0);
        tick();
        check("t1_out0_drained", out0_valid, 1'b0);

        // Alternating steering, both consumers ready
        out1_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h01);
        tick();
        check("t2_p0_v1", out0_valid, 1'b1);
        check("t2_p0_d1", out0_data,  8'h01);
        check("t2_p1_e1", out1_valid, 1'b0);
        drive(1'b1, 1'b1, 8'h02);
        tick();
        check("t2_p0_e2", out0_valid, 1'b0);
        check("t2_p1_v2", out1_valid, 1'b1);
        check("t2_p1_d2", out1_data,  8'h02);
        drive(1'b1, 1'b0, 8'h03);
        tick();
        check("t2_p0_v3", out0_valid, 1'b1);
        check("t2_p0_d3", out0_data,  8'h03);
        check("t2_p1_e3", out1_valid, 1'b0);
        drive(1'b1, 1'b1, 8'h04);
        tick();
        check("t2_p0_e4", out0_valid, 1'b0);
        check("t2_p1_v4", out1_valid, 1'b1);
        check("t2_p1_d4", out1_data,  8'h04);
        drive(1'b0, 1'b0, 8'h00);
        tick();
        check("t2_p1_drained", out1_valid, 1'b0);

        // Port 0 fills, input stalls, then drains
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h10);
        check("t3_rdy_a", in_ready, 1'b1);
        tick();
        drive(1'b1, 1'b0, 8'h11);
        check("t3_rdy_b", in_ready, 1'b1);
        tick();
        drive(1'b1, 1'b0, 8'h12);
        check("t3_rdy_full", in_ready, 1'b0);
        tick();
        check("t3_rdy_held", in_ready, 1'b0);
        check("t3_head_held", out0_data, 8'h10);
        tick();
        check("t3_p1_blocked", out1_valid, 1'b0);
        out0_ready = 1'b1;
        tick();
        check("t3_drain_v", out0_valid, 1'b1);
        check("t3_drain_d", out0_data,  8'h11);
        check("t3_rdy_free", in_ready, 1'b1);
        tick();
        check("t3_third_v", out0_valid, 1'b1);
        check("t3_third_d", out0_data,  8'h12);
        drive(1'b1, 1'b1, 8'h13);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        check("t3_p0_empty", out0_valid, 1'b0);
        check("t3_p1_v", out1_valid, 1'b1);
        check("t3_p1_d", out1_data,  8'h13);

        // Port 1 holds one entry: simultaneous push and pop
        out1_ready = 1'b1;
        drive(1'b1, 1'b1, 8'h14);
        tick();
        check("t4_v_a", out1_valid, 1'b1);
        check("t4_d_a", out1_data,  8'h14);
        drive(1'b1, 1'b1, 8'h15);
        tick();
        check("t4_v_b", out1_valid, 1'b1);
        check("t4_d_b", out1_data,  8'h15);
        drive(1'b0, 1'b0, 8'h00);
        tick();
        check("t4_count_one", out1_valid, 1'b0);

        // Asynchronous reset with port 0 full
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h20);
        tick();
        drive(1'b1, 1'b0, 8'h21);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        check("t5_full_v", out0_valid, 1'b1);
        check("t5_full_rdy", in_ready, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_v", out0_valid, 1'b0);
        check("t5_async_d", out0_data,  8'h00);
        check("t5_async_rdy", in_ready, 1'b1);
        tick();
        reset_n = 1'b1;
        tick();
        check("t5_rel_v0", out0_valid, 1'b0);
        check("t5_rel_v1", out1_valid, 1'b0);
        check("t5_rel_rdy", in_ready, 1'b1);
        check("t5_rel_d0", out0_data, 8'h00);

`ifdef DEMUX2_STREAM_STATS_EN
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 8'h30 + 8'(i));
            tick();
        end
        drive(1'b0, 1'b0, 8'h00);
        check("st_cnt1", cnt1, 16'd5);
        check("st_cnt0", cnt0, 16'd0);
        force dut.cnt0_q = 16'hFFFE;
        #1;
        release dut.cnt0_q;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'h40 + 8'(i));
            tick();
        end
        drive(1'b0, 1'b0, 8'h00);
        check("st_cnt0_sat", cnt0, 16'hFFFF);
        check("st_cnt1_hold", cnt1, 16'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
